speed_meter: RTL and testbench
==============================

# speed_meter

Quadrature-encoder speed measurement block for the motor control loop. Decodes the motor encoder's A/B channels, accumulates signed position ticks over a fixed sample window, and publishes the count as the signed 8-bit `measuredSpeed` consumed by the duty-cycle math block. It is the producer end of the `measuredSpeed` feedback interface.

## Interface

- `WINDOW_CYCLES`, default 1048576: sample window length in `clk` cycles (≥ 4).
- `ACC_W`, default 16: accumulator width in bits (≥ 9).
- `clk` in 1: 50 MHz clock.
- `reset` in 1: synchronous, active-high reset.
- `encA` in 1: encoder channel A, asynchronous.
- `encB` in 1: encoder channel B, asynchronous.
- `measuredSpeed` out 8: signed ticks per window, saturated to [-127, 127].
- `sampleValid` out 1: one-cycle pulse when `measuredSpeed` updates.
- `illegalStep` out 1: sticky flag, set on any illegal quadrature transition.

## Operation

- Synchronisation: two-flop synchroniser on each of `encA` and `encB`, giving state `q = {A_s, B_s}`.
- Priming: a `primed` bit is cleared by reset. On the first cycle after reset, the block loads `q_prev <= q`, counts nothing, and sets `primed`.
- Decode of `q_prev -> q`:
  - Forward sequence 00→01→11→10→00: delta = +1.
  - Reverse sequence: delta = -1.
  - No change: delta = 0.
  - Double change (00↔11, 01↔10): delta = 0 and `illegalStep` is set.
- Accumulator:
  - Signed `ACC_W` bits.
  - Saturates at ±(2^(ACC_W-1) - 1) and never wraps.
- Window counter: runs 0..`WINDOW_CYCLES`-1 and wraps to 0.
- Terminal cycle (count = `WINDOW_CYCLES`-1):
  - `measuredSpeed <= sat8(acc + delta)`, where sat8 clamps to [-127, 127]; -128 is never output.
  - `acc <= 0`.
  - `sampleValid <= 1`.
  - The delta from the terminal cycle belongs to the closing window.
- Outside the terminal cycle, `measuredSpeed` holds its value.
- Reset values: `measuredSpeed` = 0, `sampleValid` = 0, `illegalStep` = 0, acc = 0, window counter = 0, synchronisers = 00, `primed` = 0.
- Reset mid-window: the partial window is discarded. No `sampleValid` is produced for it, and the new window starts on the first cycle after reset deasserts.

## Timing

- Latency from encoder pin edge to acc update: 3 cycles (2 synchroniser stages plus 1 decode/accumulate).
- The first `sampleValid` is registered on the terminal cycle and is visible `WINDOW_CYCLES` cycles after reset deasserts. Later pulses occur every `WINDOW_CYCLES` cycles exactly.
- `measuredSpeed` and `sampleValid` change on the same edge, so the consumer samples `measuredSpeed` when `sampleValid` = 1.
- Maximum tick rate: 1 transition per cycle. Input edges closer together than that alias to illegal steps.

## Configuration

- `SPEED_AVG_EN` defined:
  - At each terminal cycle, the block stores the fresh saturated sample as `s_prev` (reset 0).
  - It outputs `measuredSpeed = (s_new + s_prev) >>> 1`, an arithmetic shift that rounds toward -∞.
  - The output is still within [-127, 127].
- `SPEED_AVG_EN` undefined: the output is the raw saturated sample, and no `s_prev` register exists.

## Structure

- Package `motor_pkg` holds:
  - `SPEED_W` = 8, `SPEED_MAX` = 127, `SPEED_MIN` = -127.
  - `quad_t` (2-bit A/B state).
  - Enum `quad_delta_t` {`QD_NONE`, `QD_INC`, `QD_DEC`, `QD_ILLEGAL`}.
  - Function `sat_speed()`.
- Sub-module `quad_decoder` contains the synchroniser, priming and transition decode, and outputs `quad_delta_t` each cycle.
- `speed_meter` owns the accumulator, window counter, output registers and optional averaging.

## Test plan

Unless noted, tests run with `WINDOW_CYCLES` = 64 and one quadrature step every 4 cycles.

- Reset: hold `reset` for 3 cycles with random A/B -> `measuredSpeed` = 0, `sampleValid` = 0 and `illegalStep` = 0 throughout. The first `sampleValid` arrives exactly 64 cycles after deassertion.
- Direction: 10 forward steps in one window -> `measuredSpeed` = +10 with a 1-cycle `sampleValid`. 5 reverse steps in the next window -> -5. An idle window -> 0.
- Saturation, with `WINDOW_CYCLES` = 1024 and 200 forward steps -> +127. 200 reverse steps -> -127. The accumulator keeps counting correctly after saturating.
- Illegal and window boundary:
  - Force A/B 00→11 -> no count change, `illegalStep` = 1 and held until reset.
  - A step landing on the terminal cycle -> counted in the closing window.
- Reset mid-window: 7 steps, then reset, then 3 steps -> the next sample = +3.
- With `SPEED_AVG_EN`:
  - Raw windows +10 then +20 after reset -> outputs 5, then 15.
  - Raw -3 with `s_prev` = 0 -> -2.

Source files
------------

// File: rtl/motor_pkg.sv
// Shared types and constants for the motor-control speed path.
package motor_pkg;

    localparam int SPEED_W   = 8;
    localparam int SPEED_MAX = 127;
    localparam int SPEED_MIN = -127;

    typedef logic [1:0] quad_t;

    typedef enum logic [1:0] {
        QD_NONE,
        QD_INC,
        QD_DEC,
        QD_ILLEGAL
    } quad_delta_t;

    // Symmetric clamp: -128 is never produced so the consumer can negate freely.
    function automatic logic signed [SPEED_W-1:0] sat_speed(input logic signed [31:0] i_val);
        if (i_val > SPEED_MAX) begin
            return SPEED_W'(SPEED_MAX);
        end else if (i_val < SPEED_MIN) begin
            return SPEED_W'(SPEED_MIN);
        end else begin
            return SPEED_W'(i_val);
        end
    endfunction

endpackage

// File: rtl/quad_decoder.sv
// Encoder A/B synchroniser, post-reset priming and quadrature transition decode.
module quad_decoder
    import motor_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        i_enc_a,
    input  logic        i_enc_b,
    output quad_delta_t o_delta
);

    quad_t r_sync1;
    quad_t r_sync2;
    quad_t r_q_prev;
    logic  r_primed;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_q_prev <= '0;
            r_primed <= 1'b0;
        end else begin
            r_sync1  <= {i_enc_a, i_enc_b};
            r_sync2  <= r_sync1;
            r_q_prev <= r_sync2;
            r_primed <= 1'b1;
        end
    end

    // NOTE: o_delta is assigned a default before the case so no latch is inferred.
    always_comb begin
        o_delta = QD_NONE;
        if (r_primed) begin
            case ({r_q_prev, r_sync2})
                4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: o_delta = QD_INC;
                4'b01_00, 4'b11_01, 4'b10_11, 4'b00_10: o_delta = QD_DEC;
                4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: o_delta = QD_ILLEGAL;
                default:                                o_delta = QD_NONE;
            endcase
        end
    end

endmodule

// File: rtl/speed_meter.sv
// Windowed quadrature speed measurement producing signed 8-bit ticks per window.
// Optional two-sample averaging of the published speed: define SPEED_AVG_EN.
module speed_meter
    import motor_pkg::*;
#(
    parameter int WINDOW_CYCLES = 1048576,
    parameter int ACC_W         = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      encA,
    input  logic                      encB,
    output logic signed [SPEED_W-1:0] measuredSpeed,
    output logic                      sampleValid,
    output logic                      illegalStep
);

    localparam int CNT_W = $clog2(WINDOW_CYCLES);
    localparam logic [CNT_W-1:0]       CNT_LAST = CNT_W'(WINDOW_CYCLES - 1);
    localparam logic signed [ACC_W:0]  ACC_MAX  = {2'b00, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W:0]  ACC_MIN  = -ACC_MAX;

    quad_delta_t                w_delta;
    logic signed [ACC_W:0]      w_step;
    logic signed [ACC_W:0]      w_sum;
    logic signed [ACC_W:0]      w_clamped;
    logic signed [ACC_W-1:0]    w_acc_next;
    logic signed [SPEED_W-1:0]  w_sample;
    logic signed [SPEED_W-1:0]  w_out;
    logic                       w_terminal;

    logic [CNT_W-1:0]           r_cnt;
    logic signed [ACC_W-1:0]    r_acc;
    logic signed [SPEED_W-1:0]  r_speed;
    logic                       r_valid;
    logic                       r_illegal;

    quad_decoder u_quad_decoder (
        .clk     (clk),
        .reset   (reset),
        .i_enc_a (encA),
        .i_enc_b (encB),
        .o_delta (w_delta)
    );

    // One extra bit of headroom lets the clamp see the overflow before it happens.
    always_comb begin
        w_step = '0;
        case (w_delta)
            QD_INC:  w_step = (ACC_W+1)'(1);
            QD_DEC:  w_step = -(ACC_W+1)'(1);
            default: w_step = '0;
        endcase
        w_sum     = {r_acc[ACC_W-1], r_acc} + w_step;
        w_clamped = w_sum;
        if (w_sum > ACC_MAX) begin
            w_clamped = ACC_MAX;
        end else if (w_sum < ACC_MIN) begin
            w_clamped = ACC_MIN;
        end
    end

    assign w_acc_next = w_clamped[ACC_W-1:0];
    assign w_sample   = sat_speed(32'(w_acc_next));
    assign w_terminal = (r_cnt == CNT_LAST);

`ifdef SPEED_AVG_EN
    logic signed [SPEED_W-1:0] r_s_prev;
    logic signed [SPEED_W:0]   w_avg_sum;

    // Taking the top bits of the 9-bit sum is an arithmetic shift, rounding toward -inf.
    assign w_avg_sum = {w_sample[SPEED_W-1], w_sample} + {r_s_prev[SPEED_W-1], r_s_prev};
    assign w_out     = w_avg_sum[SPEED_W:1];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s_prev <= '0;
        end else if (w_terminal) begin
            r_s_prev <= w_sample;
        end
    end
`else
    assign w_out = w_sample;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt     <= '0;
            r_acc     <= '0;
            r_speed   <= '0;
            r_valid   <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_valid <= w_terminal;
            if (w_delta == QD_ILLEGAL) begin
                r_illegal <= 1'b1;
            end
            if (w_terminal) begin
                r_cnt   <= '0;
                r_acc   <= '0;
                r_speed <= w_out;
            end else begin
                r_cnt   <= r_cnt + 1'b1;
                r_acc   <= w_acc_next;
            end
        end
    end

    assign measuredSpeed = r_speed;
    assign sampleValid   = r_valid;
    assign illegalStep   = r_illegal;

endmodule

// File: tb/tb_speed_meter.sv
// Self-checking bench for speed_meter: a 64-cycle and a 1024-cycle window instance
// against a position-counting model, plus hand-computed sample values.
module tb_speed_meter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0 = 1'b1, rst1 = 1'b1;
    logic a0 = 1'b0, b0 = 1'b0, a1 = 1'b0, b1 = 1'b0;
    logic signed [7:0] spd0, spd1;
    logic v0, v1, il0, il1;

    int n_cmp  = 0;
    int n_fail = 0;

`ifdef SPEED_AVG_EN
    localparam int E_IDLE0 = 0,  E_FWD10 = 5,  E_REV5 = 2,   E_IDLE = -3, E_ILL = 1;
    localparam int E_TERM  = 2,  E_AFTER = 0,  E_ALIGN = -1, E_MIDRST = 1;
    localparam int E_SATP  = 63, E_SATN  = 0,  E_CONT = -39;
`else
    localparam int E_IDLE0 = 0,   E_FWD10 = 10, E_REV5 = -5,  E_IDLE = 0,  E_ILL = 3;
    localparam int E_TERM  = 1,   E_AFTER = 0,  E_ALIGN = -2, E_MIDRST = 3;
    localparam int E_SATP  = 127, E_SATN  = -127, E_CONT = 50;
`endif

    speed_meter #(.WINDOW_CYCLES(64)) dut0 (
        .clk(clk), .reset(rst0), .encA(a0), .encB(b0),
        .measuredSpeed(spd0), .sampleValid(v0), .illegalStep(il0)
    );

    speed_meter #(.WINDOW_CYCLES(1024)) dut1 (
        .clk(clk), .reset(rst1), .encA(a1), .encB(b1),
        .measuredSpeed(spd1), .sampleValid(v1), .illegalStep(il1)
    );

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int win(input int i);
        return (i == 0) ? 64 : 1024;
    endfunction

    // Angular position 0..3 of each A/B code along the forward sequence.
    function automatic int code_pos(input int ab);
        case (ab)
            0: return 0;
            1: return 1;
            3: return 2;
            default: return 3;
        endcase
    endfunction

    function automatic int clamp(input int v, input int lim);
        return (v > lim) ? lim : ((v < -lim) ? -lim : v);
    endfunction

    // Model: pins pass a two-stage delay, the position change between consecutive
    // synchronised codes is counted, and windows are counted in cycles since reset.
    int  m_s1[2], m_s2[2], m_qp[2], m_acc[2], m_cnt[2], m_spd[2], m_prev[2];
    bit  m_primed[2], m_val[2], m_ill[2];

    always @(posedge clk) begin
        int  pins, d, dp, raw, sum;
        bit  r;
        for (int i = 0; i < 2; i++) begin
            r    = (i == 0) ? rst0 : rst1;
            pins = (i == 0) ? int'({a0, b0}) : int'({a1, b1});
            if (r) begin
                m_qp[i] = 0; m_acc[i] = 0; m_cnt[i] = 0; m_spd[i] = 0; m_prev[i] = 0;
                m_primed[i] = 0; m_val[i] = 0; m_ill[i] = 0;
                m_s1[i] = 0; m_s2[i] = 0;
            end else begin
                d = 0;
                if (m_primed[i]) begin
                    dp = (code_pos(m_s2[i]) - code_pos(m_qp[i]) + 4) % 4;
                    if (dp == 1) d = 1;
                    else if (dp == 3) d = -1;
                    else if (dp == 2) m_ill[i] = 1;
                end
                m_acc[i] = clamp(m_acc[i] + d, 32767);
                if (m_cnt[i] == win(i) - 1) begin
                    raw = clamp(m_acc[i], 127);
`ifdef SPEED_AVG_EN
                    sum      = raw + m_prev[i];
                    m_spd[i] = (sum >= 0) ? sum / 2 : -((1 - sum) / 2);
                    m_prev[i] = raw;
`else
                    sum      = 0;
                    m_spd[i] = raw;
`endif
                    m_val[i] = 1;
                    m_acc[i] = 0;
                    m_cnt[i] = 0;
                end else begin
                    m_val[i] = 0;
                    m_cnt[i]++;
                end
                m_qp[i]     = m_s2[i];
                m_primed[i] = 1;
                m_s2[i]     = m_s1[i];
                m_s1[i]     = pins;
            end
        end
    end

    always @(negedge clk) begin
        check("m0_speed",   spd0, m_spd[0]);
        check("m0_valid",   v0,   m_val[0]);
        check("m0_illegal", il0,  m_ill[0]);
        check("m1_speed",   spd1, m_spd[1]);
        check("m1_valid",   v1,   m_val[1]);
        check("m1_illegal", il1,  m_ill[1]);
    end

    int pos[2];

    function automatic logic [1:0] gray(input int p);
        case (p)
            0: return 2'b00;
            1: return 2'b01;
            2: return 2'b11;
            default: return 2'b10;
        endcase
    endfunction

    task automatic move(input int i, input int dir);
        pos[i] = (pos[i] + dir + 4) % 4;
        if (i == 0) {a0, b0} = gray(pos[0]);
        else        {a1, b1} = gray(pos[1]);
    endtask

    task automatic steps(input int i, input int n, input int dir);
        repeat (n) begin
            move(i, dir);
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic wait_sample(input int i, input int exp, input string name);
        bit got = 0;
        for (int k = 0; k < win(i) + 16 && !got; k++) begin
            @(negedge clk);
            got = (i == 0) ? v0 : v1;
        end
        check({name, "_arrived"}, int'(got), 1);
        if (got) check(name, (i == 0) ? spd0 : spd1, exp);
    endtask

    initial begin
        int  lat;
        bit  got;
        pos[0] = 0;
        pos[1] = 0;

        for (int k = 0; k < 3; k++) begin
            a0 = 1'($urandom);
            b0 = 1'($urandom);
            @(negedge clk);
            check("rst_speed", spd0, 0);
            check("rst_valid", v0, 0);
            check("rst_illegal", il0, 0);
        end
        {a0, b0} = 2'b00;
        rst0 = 1'b0;
        lat = 0;
        got = 0;
        while (!got && lat < 200) begin
            @(negedge clk);
            lat++;
            got = v0;
        end
        check("first_valid_latency", lat, 64);
        check("first_sample", spd0, E_IDLE0);

        steps(0, 10, 1);
        wait_sample(0, E_FWD10, "fwd10");
        @(negedge clk);
        check("valid_pulse_width", v0, 0);
        steps(0, 5, -1);
        wait_sample(0, E_REV5, "rev5");
        wait_sample(0, E_IDLE, "idle");

        steps(0, 3, 1);
        move(0, 2);
        repeat (4) @(negedge clk);
        check("illegal_set", il0, 1);
        wait_sample(0, E_ILL, "illegal_window");

        repeat (61) @(negedge clk);
        move(0, 1);
        wait_sample(0, E_TERM, "terminal_step");
        wait_sample(0, E_AFTER, "after_terminal");
        steps(0, 2, -1);
        wait_sample(0, E_ALIGN, "realign");
        check("illegal_sticky", il0, 1);

        steps(0, 7, 1);
        rst0 = 1'b1;
        repeat (2) @(negedge clk);
        check("midrst_illegal_cleared", il0, 0);
        check("midrst_speed_cleared", spd0, 0);
        rst0 = 1'b0;
        steps(0, 3, 1);
        wait_sample(0, E_MIDRST, "mid_window_reset");

        rst1 = 1'b0;
        steps(1, 200, 1);
        wait_sample(1, E_SATP, "sat_pos");
        steps(1, 200, -1);
        wait_sample(1, E_SATN, "sat_neg");
        steps(1, 150, 1);
        steps(1, 100, -1);
        wait_sample(1, E_CONT, "count_past_sat");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
